multicycle_alu: RTL
===================

Name: multicycle_alu

Overview:
- Parametrised, sequential successor to the single-cycle myALU used in the multicycle CPU datapath.
- Adds registered results, a start/ready/done handshake, and iterative multiply and unsigned divide/remainder.
- Sits in the EX stage. The control FSM asserts start and stalls on ready.
- Single-cycle ops keep 1-cycle latency. MUL and DIV take WORD_SIZE cycles.

Parameters:
- WORD_SIZE, 32: operand and result width; must be >= 4.
- SH_W, $clog2(WORD_SIZE): shift-amount width (localparam).
- CNT_W, $clog2(WORD_SIZE)+1: iteration counter width (localparam).

Ports:
- clk  in  1  system clock; everything is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- source_a  in  WORD_SIZE  operand A.
- source_b  in  WORD_SIZE  operand B.
- alu_sel  in  4  operation select; sampled at accept.
- ready  out  1  high when idle and able to accept.
- done  out  1  one-cycle pulse: output_data/zero/error are valid and updated.
- output_data  out  WORD_SIZE  registered result; held until the next done.
- zero  out  1  registered: output_data == 0.
- error  out  1  registered: reserved or disabled opcode.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: ready=1, done=0, output_data=0, zero=1, error=0, state=IDLE, counter=0.
- Reset mid-operation aborts the operation. No done is emitted for it, and ready=1 the cycle after the reset edge.
- Opcodes (alu_sel):
  - 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 SLT (signed), 6 SLL, 7 SRL, 8 SRA, 9 NOR
  - 10 MUL (low WORD_SIZE bits of the unsigned product), 11 MULHU (high WORD_SIZE bits)
  - 12 DIVU, 13 REMU
  - 14, 15 reserved
- Arithmetic rules:
  - Shifts use source_b[SH_W-1:0]. ADD/SUB wrap modulo 2^WORD_SIZE.
  - SLT result is 1 or 0, zero-extended.
- States:
  - IDLE: on start=1, latch operands and opcode.
  - ITER: one shift-add or restoring-divide step per cycle; counter counts WORD_SIZE-1 down to 0.
- Single-cycle ops (0-9, reserved):
  - Result is registered at the accept edge; done=1 in the next cycle. State stays IDLE and ready stays 1.
  - Back-to-back starts give one done per cycle.
  - Reserved opcodes: output_data=0, error=1, latency 1.
- Iterative ops (10-13):
  - Accept edge moves IDLE->ITER and drops ready.
  - After WORD_SIZE ITER edges, the result is written, done=1 for one cycle, and state returns to IDLE.
  - ready=1 in the same cycle done=1, so a start in the done cycle is accepted.
  - Accept-to-done latency is exactly WORD_SIZE cycles.
- start while ready=0 is ignored (no queueing). The operand inputs may change freely after accept.
- Division by zero skips ITER, latency 1:
  - DIVU returns all ones.
  - REMU returns source_a.
- zero and error update only at the edge that produces done; otherwise they hold.
- MUL and MULHU run separate iterations. The high half is not cached.

Optional Feature:
- Macro: MULTICYCLE_ALU_DIV_EN.
- Defined: opcodes 12/13 behave as specified above, including divide-by-zero.
- Undefined:
  - The divider datapath is not built.
  - Opcodes 12/13 are treated as reserved: output_data=0, error=1, latency 1.
  - MUL/MULHU are unaffected.

Decomposition:
- Package alu_pkg holds:
  - the 4-bit opcode constants (OP_AND..OP_REMU);
  - the state enum (ST_IDLE, ST_ITER);
  - an is_iterative(op) function.
- Sub-module alu_iter_unit holds the shared iterative datapath (accumulator, shift register, step logic for multiply and divide).
- multicycle_alu keeps the FSM, counter, combinational ops and output registers.

Test Plan:
- ADD 4+5: done 1 cycle after accept, output 9, zero 0; then SUB 5-5 back-to-back: output 0, zero 1.
- SLT 4,5 -> 1; SLT 0xFFFFFFFF,1 -> 1; SRA 0x80000000 by 4 -> 0xF8000000; SRL same -> 0x08000000.
- MUL 0x00010000 * 0x00010000:
  - output 0, zero 1; done exactly 32 cycles after accept; ready=0 throughout.
  - a start at cycle 5 is ignored.
  - MULHU of the same operands -> 1.
- DIVU 12/5 -> 2; REMU 12/5 -> 2; DIVU 7/0 -> 0xFFFFFFFF in 1 cycle; REMU 7/0 -> 7. Without the macro, DIVU -> 0 with error=1.
- reset asserted 10 cycles into a MUL:
  - next cycle ready=1, done=0, output_data=0, and no later spurious done.
  - a following ADD 2+3 -> 5.
- WORD_SIZE=8 instance: MUL 15*17 -> 255 in 8 cycles; reserved opcode 14 -> output 0, error 1, zero 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and opcode classification for multicycle_alu.
// MULTICYCLE_ALU_DIV_EN decides whether DIVU/REMU count as iterative ops.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_NOR   = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;

    typedef enum logic {
        ST_IDLE,
        ST_ITER
    } state_t;

    function automatic logic is_iterative(input logic [3:0] op);
`ifdef MULTICYCLE_ALU_DIV_EN
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
`else
        return (op == OP_MUL) || (op == OP_MULHU);
`endif
    endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the EX-stage control and multicycle_alu.
interface multicycle_alu_if #(
    parameter int WORD_SIZE = 32
);
    logic                 start;
    logic [WORD_SIZE-1:0] source_a;
    logic [WORD_SIZE-1:0] source_b;
    logic [3:0]           alu_sel;
    logic                 ready;
    logic                 done;
    logic [WORD_SIZE-1:0] output_data;
    logic                 zero;
    logic                 error;

    modport master (
        output start, source_a, source_b, alu_sel,
        input  ready, done, output_data, zero, error
    );

    modport slave (
        input  start, source_a, source_b, alu_sel,
        output ready, done, output_data, zero, error
    );
endinterface

// File: rtl/alu_iter_unit.sv
// Shared shift-add multiplier / restoring divider; one step per load or step cycle.
// The divide step exists only when MULTICYCLE_ALU_DIV_EN is defined.
module alu_iter_unit #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 load_div,
    input  logic                 step,
    input  logic [WORD_SIZE-1:0] opa,
    input  logic [WORD_SIZE-1:0] opb,
    output logic [WORD_SIZE-1:0] hi_next,
    output logic [WORD_SIZE-1:0] lo_next
);

    logic [WORD_SIZE-1:0] acc_reg, mq_reg, opnd_reg;
    logic                 div_reg;
    logic [WORD_SIZE-1:0] acc_cur, mq_cur, opnd_cur;
    logic                 div_cur;
    logic [WORD_SIZE-1:0] acc_next, mq_next;
    logic [WORD_SIZE:0]   mul_sum;

    // The load cycle already performs the first step on the fresh operands.
    always_comb begin
        if (load) begin
            acc_cur  = '0;
            mq_cur   = load_div ? opa : opb;
            opnd_cur = load_div ? opb : opa;
            div_cur  = load_div;
        end else begin
            acc_cur  = acc_reg;
            mq_cur   = mq_reg;
            opnd_cur = opnd_reg;
            div_cur  = div_reg;
        end
    end

    assign mul_sum = {1'b0, acc_cur} + (mq_cur[0] ? {1'b0, opnd_cur} : '0);

`ifdef MULTICYCLE_ALU_DIV_EN
    logic [WORD_SIZE:0]   div_shift;
    logic [WORD_SIZE+1:0] div_diff;

    assign div_shift = {acc_cur, mq_cur[WORD_SIZE-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_cur};

    always_comb begin
        acc_next = mul_sum[WORD_SIZE:1];
        mq_next  = {mul_sum[0], mq_cur[WORD_SIZE-1:1]};
        if (div_cur) begin
            if (!div_diff[WORD_SIZE+1]) begin
                acc_next = div_diff[WORD_SIZE-1:0];
                mq_next  = {mq_cur[WORD_SIZE-2:0], 1'b1};
            end else begin
                acc_next = div_shift[WORD_SIZE-1:0];
                mq_next  = {mq_cur[WORD_SIZE-2:0], 1'b0};
            end
        end
    end
`else
    logic unused_div;
    assign unused_div = div_cur;

    always_comb begin
        acc_next = mul_sum[WORD_SIZE:1];
        mq_next  = {mul_sum[0], mq_cur[WORD_SIZE-1:1]};
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg  <= '0;
            mq_reg   <= '0;
            opnd_reg <= '0;
            div_reg  <= 1'b0;
        end else if (load || step) begin
            acc_reg  <= acc_next;
            mq_reg   <= mq_next;
            opnd_reg <= opnd_cur;
            div_reg  <= div_cur;
        end
    end

    assign hi_next = acc_next;
    assign lo_next = mq_next;

endmodule

// File: rtl/multicycle_alu.sv
// Sequential EX-stage ALU: registered single-cycle ops plus iterative MUL/MULHU/DIVU/REMU.
// Define MULTICYCLE_ALU_DIV_EN to build the divider; otherwise DIVU/REMU report error.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic             clk,
    input  logic             reset,
    multicycle_alu_if.slave  bus
);

    localparam int SH_W  = $clog2(WORD_SIZE);
    localparam int CNT_W = $clog2(WORD_SIZE) + 1;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [3:0]           op_reg, op_next;
    logic                 done_reg, done_next;
    logic [WORD_SIZE-1:0] out_reg, out_next;
    logic                 zero_reg, zero_next;
    logic                 error_reg, error_next;

    logic [SH_W-1:0]      sh;
    logic [WORD_SIZE-1:0] single_res;
    logic                 single_err;
    logic                 is_div_sel;
    logic                 start_iter;
    logic                 iter_load, iter_step;
    logic [WORD_SIZE-1:0] hi_next, lo_next, iter_res;

    assign sh         = bus.source_b[SH_W-1:0];
    assign is_div_sel = (bus.alu_sel == OP_DIVU) || (bus.alu_sel == OP_REMU);
    // A zero divisor has a fixed answer, so it takes the single-cycle path.
    assign start_iter = is_iterative(bus.alu_sel) && !(is_div_sel && (bus.source_b == '0));

    always_comb begin
        single_res = '0;
        single_err = 1'b0;
        case (bus.alu_sel)
            OP_AND:  single_res = bus.source_a & bus.source_b;
            OP_OR:   single_res = bus.source_a | bus.source_b;
            OP_ADD:  single_res = bus.source_a + bus.source_b;
            OP_SUB:  single_res = bus.source_a - bus.source_b;
            OP_XOR:  single_res = bus.source_a ^ bus.source_b;
            OP_SLT:  single_res = {{(WORD_SIZE-1){1'b0}},
                                   ($signed(bus.source_a) < $signed(bus.source_b))};
            OP_SLL:  single_res = bus.source_a << sh;
            OP_SRL:  single_res = bus.source_a >> sh;
            OP_SRA:  single_res = $unsigned($signed(bus.source_a) >>> sh);
            OP_NOR:  single_res = ~(bus.source_a | bus.source_b);
`ifdef MULTICYCLE_ALU_DIV_EN
            OP_DIVU: single_res = '1;
            OP_REMU: single_res = bus.source_a;
`endif
            default: single_err = 1'b1;
        endcase
    end

    assign iter_res = ((op_reg == OP_MULHU) || (op_reg == OP_REMU)) ? hi_next : lo_next;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        done_next  = 1'b0;
        out_next   = out_reg;
        zero_next  = zero_reg;
        error_next = error_reg;
        iter_load  = 1'b0;
        iter_step  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    op_next = bus.alu_sel;
                    if (start_iter) begin
                        state_next = ST_ITER;
                        cnt_next   = CNT_W'(WORD_SIZE - 1);
                        iter_load  = 1'b1;
                    end else begin
                        done_next  = 1'b1;
                        out_next   = single_res;
                        zero_next  = (single_res == '0);
                        error_next = single_err;
                    end
                end
            end
            ST_ITER: begin
                iter_step = 1'b1;
                // The accept edge did step one, so the edge seen with cnt==1 is the last.
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                    out_next   = iter_res;
                    zero_next  = (iter_res == '0);
                    error_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
            done_reg  <= 1'b0;
            out_reg   <= '0;
            zero_reg  <= 1'b1;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            done_reg  <= done_next;
            out_reg   <= out_next;
            zero_reg  <= zero_next;
            error_reg <= error_next;
        end
    end

    alu_iter_unit #(
        .WORD_SIZE (WORD_SIZE)
    ) u_iter (
        .clk      (clk),
        .reset    (reset),
        .load     (iter_load),
        .load_div (is_div_sel),
        .step     (iter_step),
        .opa      (bus.source_a),
        .opb      (bus.source_b),
        .hi_next  (hi_next),
        .lo_next  (lo_next)
    );

    assign bus.ready       = (state_reg == ST_IDLE);
    assign bus.done        = done_reg;
    assign bus.output_data = out_reg;
    assign bus.zero        = zero_reg;
    assign bus.error       = error_reg;

endmodule
